prefetch_queue: RTL and testbench



---
 rtl/prefetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_prefetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch unit. Fetches 16-bit words from code
// memory at CS:IP and buffers them as bytes in a circular FIFO. The decoder
// takes one byte per cycle, and any control transfer flushes the queue.
// Optional build macro PREFETCH_BYPASS_EN: when the queue is empty, the first
// byte of a returning word reaches the outputs in the same cycle as
// bus_command_done.
module prefetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [15:0]              new_cs,
  input  logic [15:0]              new_ip,
  output logic [7:0]               byte_out,
  output logic [15:0]              byte_ip,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [1:0]               bus_command,
  output logic [19:0]              bus_address,
  input  logic [15:0]              data_in,
  input  logic                     bus_command_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;

  typedef enum logic {IDLE = 1'b0, FETCH_WAIT = 1'b1} state_t;

  // Word-aligned 20-bit physical address of seg:off
  function automatic logic [19:0] fetch_phys(input logic [15:0] seg, input logic [15:0] off);
    logic [19:0] sum;
    sum = {seg, 4'h0} + {4'h0, off};
    return {sum[19:1], 1'b0};
  endfunction

  state_t          state;
  logic [15:0]     cs;
  logic [15:0]     fetch_ip;
  logic            discard;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [7:0]      byte_out_r;
  logic [15:0]     byte_ip_r;
  logic            byte_valid_r;

  logic            push;
  logic [1:0]      push_n;
  logic [7:0]      b0;
  logic [7:0]      b1;
  logic            byp;
  logic            pop;
  logic            issue;
  logic [CW-1:0]   free_space;
  logic [CW-1:0]   need;
  logic [PW-1:0]   head_nxt;
  logic [PW-1:0]   tail1;
  logic [CW-1:0]   count_nxt;
  logic [7:0]      head_byte;

  assign push   = (state == FETCH_WAIT) && bus_command_done && !discard && !flush;
  assign push_n = !push ? 2'd0 : (fetch_ip[0] ? 2'd1 : 2'd2);
  // An odd fetch_ip only wants the upper byte of the aligned word
  assign b0     = fetch_ip[0] ? data_in[15:8] : data_in[7:0];
  assign b1     = data_in[15:8];

`ifdef PREFETCH_BYPASS_EN
  assign byp = push && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign byte_valid  = byte_valid_r | byp;
  assign byte_out    = byp ? b0 : byte_out_r;
  assign byte_ip     = byp ? fetch_ip : byte_ip_r;
  assign queue_count = count;

  assign pop        = byte_valid && byte_ready && !flush;
  // Space check deliberately ignores this cycle's pop
  assign free_space = CW'(DEPTH) - count;
  assign need       = fetch_ip[0] ? CW'(1) : CW'(2);
  assign issue      = (state == IDLE) && !flush && (free_space >= need);

  assign head_nxt  = head + PW'(pop);
  assign tail1     = tail + PW'(1);
  assign count_nxt = count + CW'(push_n) - CW'(pop);

  // Byte at the post-update head, taking this cycle's writes into account
  always_comb begin
    head_byte = mem[head_nxt];
    if (push_n != 2'd0 && head_nxt == tail)
      head_byte = b0;
    else if (push_n == 2'd2 && head_nxt == tail1)
      head_byte = b1;
  end

  // Fetch FSM: bus handshake, segment/IP tracking and stale-read discard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_command <= CMD_IDLE;
      bus_address <= 20'h0;
      discard     <= 1'b0;
      cs          <= RESET_CS;
      fetch_ip    <= RESET_IP;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state       <= FETCH_WAIT;
            bus_command <= CMD_READ;
            bus_address <= fetch_phys(cs, fetch_ip);
          end
        end
        FETCH_WAIT: begin
          if (bus_command_done) begin
            state       <= IDLE;
            bus_command <= CMD_IDLE;
            discard     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (push)
        fetch_ip <= fetch_ip + 16'(push_n);
      if (flush) begin
        cs       <= new_cs;
        fetch_ip <= new_ip;
        discard  <= (state == FETCH_WAIT) && !bus_command_done;
      end
    end
  end

  // Byte storage; contents behind the head are don't-care so no reset
  always_ff @(posedge clk) begin
    if (push_n != 2'd0)
      mem[tail] <= b0;
    if (push_n == 2'd2)
      mem[tail1] <= b1;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail + PW'(push_n);
      count <= count_nxt;
    end
  end

  // Registered head view presented to the decoder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_out_r   <= 8'h0;
      byte_ip_r    <= RESET_IP;
      byte_valid_r <= 1'b0;
    end else if (flush) begin
      byte_out_r   <= 8'h0;
      byte_ip_r    <= new_ip;
      byte_valid_r <= 1'b0;
    end else begin
      byte_out_r   <= head_byte;
      byte_ip_r    <= byte_ip + 16'(pop);
      byte_valid_r <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: randomized bench for prefetch_queue with a queue-based
// reference model and a reactive bus memory. Builds with or without
// PREFETCH_BYPASS_EN.
module tb_prefetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] new_cs = 16'h0;
  logic [15:0] new_ip = 16'h0;
  logic        byte_ready = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        bus_command_done = 1'b0;
  logic [7:0]  byte_out;
  logic [15:0] byte_ip;
  logic        byte_valid;
  logic [3:0]  queue_count;
  logic [1:0]  bus_command;
  logic [19:0] bus_address;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_CS(16'hFFFF), .RESET_IP(16'h0000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .new_cs(new_cs), .new_ip(new_ip),
    .byte_out(byte_out), .byte_ip(byte_ip), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .queue_count(queue_count),
    .bus_command(bus_command), .bus_address(bus_address),
    .data_in(data_in), .bus_command_done(bus_command_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state: queue of {ip, byte}
  logic [23:0] q[$];
  logic [15:0] m_cs, m_fip;
  logic [19:0] m_addr;
  bit          m_busy, m_disc;

  // bus responder state
  bit rd_active;
  int wait_cnt;
  int lat_cfg;

  // observation logs
  logic [19:0] addr_log[$];
  logic [23:0] pop_log[$];
  bit          prev_read;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memw(input logic [19:0] a);
    if (a == 20'hFFFF0) return 16'hBBAA;
    if (a == 20'h10004) return 16'h3412;
    if (a == 20'h00010) return 16'h5678;
    return {a[8:1], a[16:9]} ^ 16'hC3A5;
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] s, input logic [15:0] o);
    int unsigned lin;
    lin = ((int'(s) * 16) + int'(o)) % (1 << 20);
    return 20'(lin & 32'hFFFFE);
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    if (i < addr_log.size()) return 32'(addr_log[i]);
    return 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (i < pop_log.size()) return 32'(pop_log[i]);
    return 32'hFFFFFFFF;
  endfunction

  function automatic bit bypass_exp();
`ifdef PREFETCH_BYPASS_EN
    return (q.size() == 0) && m_busy && bus_command_done && !m_disc && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [23:0] head_exp();
    logic [15:0] w;
    if (q.size() > 0) return q[0];
    w = memw(m_addr);
    return {m_fip, (m_fip[0] ? w[15:8] : w[7:0])};
  endfunction

  task automatic model_init();
    q.delete();
    m_cs = 16'hFFFF; m_fip = 16'h0000; m_addr = 20'h0;
    m_busy = 0; m_disc = 0;
  endtask

  // advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    bit vld, pop, issue, done_now;
    logic [15:0] w;
    vld      = (q.size() > 0) || bypass_exp();
    pop      = vld && byte_ready && !flush;
    issue    = !m_busy && !flush && ((DEPTH - q.size()) >= (m_fip[0] ? 1 : 2));
    done_now = m_busy && bus_command_done;
    if (flush) begin
      q.delete();
      m_cs = new_cs; m_fip = new_ip;
      m_disc = m_busy && !bus_command_done;
    end else begin
      if (done_now && !m_disc) begin
        w = memw(m_addr);
        if (m_fip[0]) begin
          q.push_back({m_fip, w[15:8]});
          m_fip = m_fip + 16'd1;
        end else begin
          q.push_back({m_fip, w[7:0]});
          q.push_back({m_fip + 16'd1, w[15:8]});
          m_fip = m_fip + 16'd2;
        end
      end
      if (pop) void'(q.pop_front());
    end
    if (done_now) begin
      m_busy = 0;
      m_disc = 0;
    end else if (issue) begin
      m_busy = 1;
      m_addr = phys(m_cs, m_fip);
    end
  endtask

  task automatic check_outputs();
    bit vld;
    logic [23:0] h;
    vld = (q.size() > 0) || bypass_exp();
    chk("bus_command", 32'(bus_command), m_busy ? 32'd1 : 32'd0);
    if (m_busy) chk("bus_address", 32'(bus_address), 32'(m_addr));
    chk("byte_valid", 32'(byte_valid), 32'(vld));
    if (vld) begin
      h = head_exp();
      chk("byte_out", 32'(byte_out), 32'(h[7:0]));
      chk("byte_ip", 32'(byte_ip), 32'(h[23:8]));
    end
    chk("queue_count", 32'(queue_count), 32'(q.size()));
    if (bus_command == 2'd1 && !prev_read) addr_log.push_back(bus_address);
    prev_read = (bus_command == 2'd1);
    if (byte_valid && byte_ready && !flush) pop_log.push_back({byte_ip, byte_out});
  endtask

  // one clock: model update at the edge, bus response after it, check at negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    bus_command_done = 1'b0;
    data_in = 16'($urandom);
    if (!rd_active && bus_command == 2'd1) begin
      rd_active = 1;
      wait_cnt  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
    if (rd_active) begin
      if (wait_cnt == 0) begin
        bus_command_done = 1'b1;
        data_in = memw(bus_address);
        rd_active = 0;
      end else begin
        wait_cnt--;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus_command_done = 1'b0;
    rd_active = 0;
    prev_read = 0;
    model_init();
    #2;
    chk("rst_bus_command", 32'(bus_command), 32'd0);
    chk("rst_bus_address", 32'(bus_address), 32'h0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'h0);
    chk("rst_byte_ip", 32'(byte_ip), 32'h0000);
    chk("rst_queue_count", 32'(queue_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_flush(input logic [15:0] c, input logic [15:0] i);
    new_cs = c; new_ip = i; flush = 1'b1;
    cycle();
    flush = 1'b0;
    addr_log.delete();
    pop_log.delete();
  endtask

  initial begin
    bit found;
    lat_cfg = 0;
    do_reset();

    // reset vector fetch, 1-cycle bus, decoder always ready
    byte_ready = 1'b1;
    addr_log.delete(); pop_log.delete();
    repeat (8) cycle();
    chk("t1_first_read", addr_at(0), 32'h0FFFF0);
    chk("t1_second_read", addr_at(1), 32'h0FFFF2);
    chk("t1_pop0", pop_at(0), 32'h0000AA);
    chk("t1_pop1", pop_at(1), 32'h0001BB);

    // flush to an odd IP: only the upper byte of the word is used
    pulse_flush(16'h1000, 16'h0005);
    repeat (10) cycle();
    chk("t2_read_addr", addr_at(0), 32'h10004);
    chk("t2_next_read", addr_at(1), 32'h10006);
    chk("t2_pop0", pop_at(0), 32'h000534);

    // fill to capacity with the decoder stalled
    byte_ready = 1'b0;
    pulse_flush(16'h0000, 16'h0000);
    repeat (30) cycle();
    chk("t3_full_count", 32'(queue_count), 32'd8);
    chk("t3_full_reads", 32'(addr_log.size()), 32'd4);
    chk("t3_full_idle", 32'(bus_command), 32'd0);
    byte_ready = 1'b1; cycle(); byte_ready = 1'b0;
    repeat (6) cycle();
    chk("t3_one_pop_count", 32'(queue_count), 32'd7);
    chk("t3_one_pop_reads", 32'(addr_log.size()), 32'd4);
    byte_ready = 1'b1; cycle(); byte_ready = 1'b0;
    repeat (6) cycle();
    chk("t3_two_pop_reads", 32'(addr_log.size()), 32'd5);
    chk("t3_refill_count", 32'(queue_count), 32'd8);

    // flush while a slow read is outstanding
    byte_ready = 1'b1;
    lat_cfg = 3;
    pulse_flush(16'h0000, 16'h0100);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_command == 2'd1) begin found = 1; break; end
      cycle();
    end
    chk("t4_read_seen", 32'(found), 32'd1);
    chk("t4_old_addr", 32'(bus_address), 32'h00100);
    pulse_flush(16'h0000, 16'h0200);
    repeat (15) cycle();
    chk("t4_new_addr", addr_at(0), 32'h00200);
    chk("t4_first_ip", pop_at(0) >> 8, 32'h0200);

    // IP and segment wrap
    lat_cfg = 0;
    pulse_flush(16'h0000, 16'hFFFE);
    repeat (10) cycle();
    chk("t5_addr0", addr_at(0), 32'h0FFFE);
    chk("t5_addr1", addr_at(1), 32'h00000);
    chk("t5_ip0", pop_at(0) >> 8, 32'hFFFE);
    chk("t5_ip1", pop_at(1) >> 8, 32'hFFFF);
    chk("t5_ip2", pop_at(2) >> 8, 32'h0000);

    // first-byte latency into an empty queue
    byte_ready = 1'b0;
    lat_cfg = 1;
    pulse_flush(16'h0000, 16'h0010);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus_command_done && bus_address == 20'h00010) begin found = 1; break; end
    end
    chk("t6_done_seen", 32'(found), 32'd1);
`ifdef PREFETCH_BYPASS_EN
    chk("t6_bypass_valid", 32'(byte_valid), 32'd1);
    chk("t6_bypass_byte", 32'(byte_out), 32'h78);
`else
    chk("t6_done_valid", 32'(byte_valid), 32'd0);
`endif
    cycle();
    chk("t6_next_valid", 32'(byte_valid), 32'd1);
    chk("t6_next_byte", 32'(byte_out), 32'h78);
    chk("t6_next_ip", 32'(byte_ip), 32'h0010);

    // randomized traffic with flushes and one mid-run reset
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      byte_ready = ($urandom_range(0, 3) < ((i / 500) % 4)) ? 1'b0 : 1'b1;
      flush = ($urandom_range(0, 39) == 0);
      if (flush) begin
        new_cs = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        new_ip = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      end
      cycle();
      flush = 1'b0;
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
